// File: rtl/kmkz_trap_ctrl_if.sv
// Execute-stage <-> trap controller signal bundle; master = pipeline, slave = controller.
interface kmkz_trap_ctrl_if #(
   parameter int unsigned NUM_IRQ = 8
);
   logic               x_stall_i;
   logic               x_kill_i;
   logic               d_is_csr_i;
   logic               d_is_eret_i;
   logic [11:0]        d_csr_sel_i;
   logic [31:0]        x_csr_write_value_i;
   logic [3:0]         exp_sync_i;
   logic               exp_tick_i;
   logic [NUM_IRQ-1:0] irq_i;
   logic [31:0]        x_exception_pc_i;
   logic               x_exception_o;
   logic [31:0]        x_exception_pc_o;
   logic [31:0]        x_exception_vector_o;
   logic [31:0]        csr_mstatus_o;
   logic [31:0]        csr_mip_o;
   logic [31:0]        csr_mie_o;
   logic [31:0]        csr_mepc_o;
   logic [31:0]        csr_mcause_o;

   modport master (
      output x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i, d_csr_sel_i, x_csr_write_value_i,
             exp_sync_i, exp_tick_i, irq_i, x_exception_pc_i,
      input  x_exception_o, x_exception_pc_o, x_exception_vector_o, csr_mstatus_o,
             csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o
   );

   modport slave (
      input  x_stall_i, x_kill_i, d_is_csr_i, d_is_eret_i, d_csr_sel_i, x_csr_write_value_i,
             exp_sync_i, exp_tick_i, irq_i, x_exception_pc_i,
      output x_exception_o, x_exception_pc_o, x_exception_vector_o, csr_mstatus_o,
             csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o
   );
endinterface

// File: rtl/kmkz_trap_ctrl.sv
// Trap/interrupt controller for the Kamikaze-uRV execute stage: pending/enable CSRs, priority, RUN/TRAP FSM.
// Optional KMKZ_TRAP_VECTORED_EN: interrupts vector to TRAP_BASE + 4*cause.
module kmkz_trap_ctrl #(
   parameter int unsigned NUM_IRQ   = 8,
   parameter logic [15:0] IRQ_EDGE  = 16'h0000,
   parameter logic [31:0] TRAP_BASE = 32'h0000_0008
) (
   input logic             clk_i,
   input logic             rst_i,
   kmkz_trap_ctrl_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [XLEN-1:0] IRQ_MASK   = XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
   localparam logic [XLEN-1:0] MIE_MASK   = IRQ_MASK | XLEN'(32'h80);
   localparam logic [XLEN-1:0] EDGE_MASK  = XLEN'({IRQ_EDGE, 16'h0000}) & IRQ_MASK;
   localparam logic [XLEN-1:0] LEVEL_MASK = IRQ_MASK & ~EDGE_MASK;

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

   state_e             state_q, state_d;
   logic               mst_mie_q, mst_mie_d;
   logic               mst_mpie_q, mst_mpie_d;
   logic [XLEN-1:0]    mie_q, mie_d;
   logic [XLEN-1:0]    mip_lat_q, mip_lat_d;
   logic [NUM_IRQ-1:0] hist_q;
   logic [XLEN-1:0]    mepc_q, mepc_d;
   logic [XLEN-1:0]    mcause_q, mcause_d;

   logic            upd_c, csr_we_c, take_c;
   logic [XLEN-1:0] irq_w_c, mip_c, elig_c, cause_c, vector_c;

   assign upd_c    = !bus.x_stall_i && !bus.x_kill_i;
   assign csr_we_c = upd_c && bus.d_is_csr_i;
   assign irq_w_c  = XLEN'(bus.irq_i) << 16;
   assign mip_c    = mip_lat_q | (irq_w_c & LEVEL_MASK);
   assign elig_c   = mip_c & mie_q & {XLEN{mst_mie_q}};
   assign take_c   = (state_q == RUN) && ((|bus.exp_sync_i) || (|elig_c));

   // Priority encode: later assignments win, so the highest priority is written last.
   always_comb begin
      cause_c = '0;
      if (elig_c[7]) cause_c = 32'h8000_0007;
      for (int n = int'(NUM_IRQ) - 1; n >= 0; n--) begin
         if (elig_c[16+n]) cause_c = 32'h8000_0000 | XLEN'(16 + n);
      end
      if (bus.exp_sync_i[3]) cause_c = 32'd6;
      if (bus.exp_sync_i[2]) cause_c = 32'd4;
      if (bus.exp_sync_i[1]) cause_c = 32'd3;
      if (bus.exp_sync_i[0]) cause_c = 32'd2;
   end

`ifdef KMKZ_TRAP_VECTORED_EN
   assign vector_c = cause_c[31] ? TRAP_BASE + XLEN'({cause_c[4:0], 2'b00}) : TRAP_BASE;
`else
   assign vector_c = TRAP_BASE;
`endif

   // Next state; trap entry and eret override CSR writes to mstatus/mepc.
   always_comb begin
      state_d    = state_q;
      mst_mie_d  = mst_mie_q;
      mst_mpie_d = mst_mpie_q;
      mie_d      = mie_q;
      mip_lat_d  = mip_lat_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (csr_we_c) begin
         unique case (bus.d_csr_sel_i)
            CSR_MSTATUS: begin
               mst_mie_d  = bus.x_csr_write_value_i[3];
               mst_mpie_d = bus.x_csr_write_value_i[7];
            end
            CSR_MIE:  mie_d     = bus.x_csr_write_value_i & MIE_MASK;
            CSR_MIP:  mip_lat_d = mip_lat_q & bus.x_csr_write_value_i;
            CSR_MEPC: mepc_d    = bus.x_csr_write_value_i;
            default: ;
         endcase
      end
      if (upd_c) begin
         unique case (state_q)
            RUN: if (take_c) begin
               state_d    = TRAP;
               mepc_d     = bus.x_exception_pc_i;
               mcause_d   = cause_c;
               mst_mpie_d = mst_mie_q;
               mst_mie_d  = 1'b0;
            end
            TRAP: if (bus.d_is_eret_i) begin
               state_d    = RUN;
               mst_mie_d  = mst_mpie_q;
               mst_mpie_d = 1'b1;
            end
            default: ;
         endcase
      end
      // New tick/edge events are captured regardless of stall and beat a same-cycle clear.
      mip_lat_d = mip_lat_d | (XLEN'(bus.exp_tick_i) << 7)
                            | (XLEN'(bus.irq_i & ~hist_q) << 16 & EDGE_MASK);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mip_lat_q  <= '0;
         hist_q     <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         mie_q      <= mie_d;
         mip_lat_q  <= mip_lat_d;
         hist_q     <= bus.irq_i;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

   assign bus.x_exception_o        = take_c;
   assign bus.x_exception_pc_o     = mepc_q;
   assign bus.x_exception_vector_o = vector_c;
   assign bus.csr_mstatus_o        = {24'h0, mst_mpie_q, 3'b000, mst_mie_q, 3'b000};
   assign bus.csr_mip_o            = mip_c;
   assign bus.csr_mie_o            = mie_q;
   assign bus.csr_mepc_o           = mepc_q;
   assign bus.csr_mcause_o         = mcause_q;
endmodule

// File: tb/tb_kmkz_trap_ctrl.sv
// Scoreboard bench for kmkz_trap_ctrl: driver pushes per-cycle expected outputs from a reference model,
// a negedge monitor pops and compares.
module tb_kmkz_trap_ctrl;
   localparam int unsigned NUM_IRQ   = 4;
   localparam logic [15:0] IRQ_EDGE  = 16'h000A;
   localparam logic [31:0] TRAP_BASE = 32'h0000_0200;

   typedef struct {
      logic        exc;
      logic [31:0] vec, pc_o, mstatus, mip, mie, mepc, mcause;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   kmkz_trap_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();
   kmkz_trap_ctrl #(.NUM_IRQ(NUM_IRQ), .IRQ_EDGE(IRQ_EDGE), .TRAP_BASE(TRAP_BASE)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
   );

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;

   // stimulus for the next cycle
   logic               in_rst, in_stall, in_kill, in_csr, in_eret, in_tick;
   logic [11:0]        in_sel;
   logic [31:0]        in_wd, in_pc;
   logic [3:0]         in_sync;
   logic [NUM_IRQ-1:0] in_irq;

   // reference model state
   logic               m_trap, m_mie, m_mpie;
   logic [31:0]        m_mie_en, m_lat, m_mepc, m_mcause;
   logic [NUM_IRQ-1:0] m_hist;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   function automatic logic [31:0] mie_mask();
      logic [31:0] m = 32'h80;
      for (int n = 0; n < int'(NUM_IRQ); n++) m[16+n] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      m_trap = 0; m_mie = 0; m_mpie = 0;
      m_mie_en = '0; m_lat = '0; m_mepc = '0; m_mcause = '0; m_hist = '0;
   endtask

   task automatic idle();
      in_stall = 0; in_kill = 0; in_csr = 0; in_eret = 0; in_tick = 0;
      in_sel = '0; in_wd = '0; in_pc = '0; in_sync = '0; in_irq = '0;
   endtask

   task automatic csr_wr(input logic [11:0] sel, input logic [31:0] wd);
      idle(); in_csr = 1; in_sel = sel; in_wd = wd;
   endtask

   // Apply one cycle of stimulus, push expected outputs, advance the model across the next edge.
   task automatic step();
      exp_t        e;
      logic [31:0] mip, pend, cause;
      logic [31:0] cand[$];
      logic [31:0] sync_code [4];
      logic        take, upd;
      sync_code[0] = 32'd2; sync_code[1] = 32'd3; sync_code[2] = 32'd4; sync_code[3] = 32'd6;
      if (!in_rst) begin
         idle();
         model_reset();
      end
      rst_i = in_rst;
      bus.x_stall_i = in_stall; bus.x_kill_i = in_kill; bus.d_is_csr_i = in_csr;
      bus.d_is_eret_i = in_eret; bus.d_csr_sel_i = in_sel; bus.x_csr_write_value_i = in_wd;
      bus.exp_sync_i = in_sync; bus.exp_tick_i = in_tick; bus.irq_i = in_irq;
      bus.x_exception_pc_i = in_pc;

      mip = m_lat;
      for (int n = 0; n < int'(NUM_IRQ); n++)
         if (!IRQ_EDGE[n] && in_irq[n]) mip[16+n] = 1'b1;
      pend = m_mie ? (mip & m_mie_en) : 32'h0;
      for (int i = 0; i < 4; i++) if (in_sync[i]) cand.push_back(sync_code[i]);
      for (int n = 0; n < int'(NUM_IRQ); n++) if (pend[16+n]) cand.push_back(32'h8000_0010 + 32'(n));
      if (pend[7]) cand.push_back(32'h8000_0007);
      cause = (cand.size() != 0) ? cand[0] : 32'h0;
      take  = !m_trap && (cand.size() != 0);

      e.exc  = take;
`ifdef KMKZ_TRAP_VECTORED_EN
      e.vec  = cause[31] ? TRAP_BASE + 32'(cause[4:0]) * 32'd4 : TRAP_BASE;
`else
      e.vec  = TRAP_BASE;
`endif
      e.pc_o = m_mepc; e.mepc = m_mepc; e.mcause = m_mcause;
      e.mstatus = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      e.mip = mip; e.mie = m_mie_en;
      sb_q.push_back(e);

      if (in_rst) begin
         upd = !in_stall && !in_kill;
         if (upd && in_csr) begin
            if (in_sel == 12'h304) m_mie_en = in_wd & mie_mask();
            if (in_sel == 12'h344) m_lat = m_lat & in_wd;
            if (in_sel == 12'h341 && !take) m_mepc = in_wd;
            if (in_sel == 12'h300 && !take && !(m_trap && in_eret)) begin
               m_mie = in_wd[3]; m_mpie = in_wd[7];
            end
         end
         if (upd && take) begin
            m_trap = 1; m_mepc = in_pc; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
         end else if (upd && m_trap && in_eret) begin
            m_trap = 0; m_mie = m_mpie; m_mpie = 1;
         end
         if (in_tick) m_lat[7] = 1'b1;
         for (int n = 0; n < int'(NUM_IRQ); n++)
            if (IRQ_EDGE[n] && in_irq[n] && !m_hist[n]) m_lat[16+n] = 1'b1;
         m_hist = in_irq;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("x_exception", 32'(bus.x_exception_o), 32'(e.exc));
            chk("vector", bus.x_exception_vector_o, e.vec);
            chk("exc_pc", bus.x_exception_pc_o, e.pc_o);
            chk("mstatus", bus.csr_mstatus_o, e.mstatus);
            chk("mip", bus.csr_mip_o, e.mip);
            chk("mie", bus.csr_mie_o, e.mie);
            chk("mepc", bus.csr_mepc_o, e.mepc);
            chk("mcause", bus.csr_mcause_o, e.mcause);
         end
      end
   end

   initial begin
      logic [11:0] sels [5];
      sels[0] = 12'h300; sels[1] = 12'h304; sels[2] = 12'h341; sels[3] = 12'h344; sels[4] = 12'h305;
      in_rst = 0; idle(); model_reset();
      rst_i = 0;
      bus.x_stall_i = 0; bus.x_kill_i = 0; bus.d_is_csr_i = 0; bus.d_is_eret_i = 0;
      bus.d_csr_sel_i = '0; bus.x_csr_write_value_i = '0; bus.exp_sync_i = '0;
      bus.exp_tick_i = 0; bus.irq_i = '0; bus.x_exception_pc_i = '0;
      @(posedge clk_i); #1;
      repeat (2) step();
      in_rst = 1;
      // illegal instruction at 0x100, then eret
      idle(); step();
      idle(); in_sync = 4'b0001; in_pc = 32'h100; step();
      idle(); step();
      idle(); in_eret = 1; step();
      // edge line 1 interrupt, eret, then clear pending via MIP
      csr_wr(12'h300, 32'h8); step();
      csr_wr(12'h304, 32'h1 << 17); step();
      idle(); in_irq = 4'b0010; step();
      idle(); step(); step();
      idle(); in_eret = 1; step();
      idle(); step();
      csr_wr(12'h304, 32'h0); step();
      csr_wr(12'h344, 32'h0); step();
      // level lines 0 and 2 with tick, all enabled
      csr_wr(12'h304, 32'hFFFF_FFFF); step();
      csr_wr(12'h300, 32'h8); step();
      idle(); in_irq = 4'b0101; in_tick = 1; in_pc = 32'h240; step();
      idle(); in_irq = 4'b0101; step();
      idle(); in_eret = 1; step();
      // illegal + tick + irq 0 together, irq 0 next after eret
      idle(); in_sync = 4'b0001; in_tick = 1; in_irq = 4'b0001; in_pc = 32'h300; step();
      idle(); in_irq = 4'b0001; in_eret = 1; step();
      idle(); in_irq = 4'b0001; in_pc = 32'h304; step();
      idle(); in_eret = 1; step();
      // stalled trap request
      csr_wr(12'h300, 32'h0); step();
      for (int i = 0; i < 3; i++) begin
         idle(); in_sync = 4'b0100; in_pc = 32'h400; in_stall = 1; step();
      end
      idle(); in_sync = 4'b0100; in_pc = 32'h400; step();
      // reset while trapped with a pending tick
      idle(); in_tick = 1; step();
      in_rst = 0; step(); step();
      in_rst = 1; idle(); step();

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         logic [NUM_IRQ-1:0] irq_keep;
         irq_keep = in_irq;
         idle();
         in_irq   = irq_keep ^ (NUM_IRQ'($urandom) & NUM_IRQ'($urandom));
         in_stall = ($urandom_range(0, 7) == 0);
         in_kill  = ($urandom_range(0, 11) == 0);
         in_tick  = ($urandom_range(0, 9) == 0);
         in_eret  = ($urandom_range(0, 2) == 0);
         in_sync  = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         in_pc    = $urandom & 32'hFFFF_FFFC;
         in_csr   = ($urandom_range(0, 3) == 0);
         in_sel   = sels[$urandom_range(0, 4)];
         in_wd    = $urandom;
         if (in_sel == 12'h300 && $urandom_range(0, 1) == 1) in_wd[3] = 1'b1;
         in_rst   = ($urandom_range(0, 599) != 0);
         step();
      end
      in_rst = 1; idle(); step();
      @(negedge clk_i);
      #1;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
